decode_imm_ctrl: RTL and testbench
==================================

// Module: decode_imm_ctrl
// PURPOSE
//  Fetch->execute decode-stage controller around the immediate datapath. Accepts
//  {inst,pc} from fetch via valid/ready, classifies the opcode, selects and
//  sign-extends the matching RV32I immediate, and buffers results in a 2-entry
//  skid queue toward execute. Supports full throughput, backpressure and flush.
// PARAMETERS
//  XLEN      32            datapath width; only 32 supported
//  NOP_INST  32'h0000_0013 value on inst_o when valid_o=0 (addi x0,x0,0)
// PORTS
//  clk_i         in   1     clock, rising edge
//  rst_ni        in   1     async reset, active low
//  valid_i       in   1     fetch has {inst_i,pc_i}
//  ready_o       out  1     controller can accept this cycle
//  inst_i        in   32    instruction word
//  pc_i          in   XLEN  instruction PC
//  flush_i       in   1     sync flush: drop all buffered and incoming entries
//  valid_o       out  1     head entry valid toward execute
//  ready_i       in   1     execute accepts head entry
//  inst_o        out  32    head instruction
//  pc_o          out  XLEN  head PC
//  imm_o         out  XLEN  head immediate, sign-extended
//  imm_type_o    out  3     0 NONE,1 I,2 S,3 B,4 U,5 J
//  tgt_o         out  XLEN  branch/jump target (only with DECODE_BR_TARGET_EN)
// BEHAVIOUR
//  - One clock; asynchronous active-low reset. Reset: count=0, valid_o=0,
//    inst_o=NOP_INST, pc_o=0, imm_o=0, imm_type_o=0, tgt_o=0, ready_o=1.
//  - State = occupancy count EMPTY(0)/ONE(1)/FULL(2); ready_o=(count!=FULL),
//    driven from state only (no comb path from valid_i/ready_i).
//  - push=valid_i&ready_o&~flush_i; pop=valid_o&ready_i&~flush_i.
//    EMPTY: push->ONE. ONE: push&~pop->FULL; pop&~push->EMPTY; both->ONE.
//    FULL: pop->ONE (no push possible). FIFO order always preserved.
//  - Latency: push in cycle N -> valid_o in N+1 when queue empty or draining.
//  - Decode at input, stored per entry (opcode=inst[6:0]):
//    I 0010011/0000011/1100111: {{20{i[31]}},i[31:20]}
//    S 0100011: {{20{i[31]}},i[31:25],i[11:7]}
//    B 1100011: {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}
//    U 0110111/0010111: {i[31:12],12'b0}
//    J 1101111: {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}
//    other opcodes: type NONE, imm 0; entry still passed through.
//  - flush_i: next cycle count=0, valid_o=0, outputs back to reset values,
//    ready_o=1; flush wins over simultaneous push/pop (input dropped,
//    head not consumed).
//  - Output regs hold stable while valid_o&~ready_i.
//  - Reset asserted mid-operation: immediate return to reset values, all
//    entries lost.
// CONFIGURATION
//  DECODE_BR_TARGET_EN defined: tgt_o present, per entry: B/J -> pc+imm,
//    else pc+4; 32-bit add wraps mod 2^32; same latency as imm_o.
//  Undefined: tgt_o port and adder absent; all other behaviour identical.
// TESTING
//  1 inst 0xFE000EE3 pc 0x100, ready_i=1 -> next cycle valid_o=1, type 3,
//    imm 0xFFFFFFFC, tgt_o 0x000000FC
//  2 inst 0x00512423 (sw) -> type 2, imm 0x00000008; inst 0x123450B7 (lui)
//    -> type 4, imm 0x12345000; inst 0x0080006F (jal) -> type 5, imm 0x8
//  3 ready_i=0, push A,B,C back-to-back -> A,B accepted, ready_o=0 after B,
//    C held by fetch; ready_i=1 -> A,B,C out in order, no loss/duplication
//  4 FULL + flush_i with valid_i=1 -> next cycle valid_o=0, ready_o=1,
//    flushed input never appears on outputs
//  5 pc 0xFFFFFFFC with jal imm 8 (EN defined) -> tgt_o 0x00000004 (wrap);
//    opcode 0x33 (R-type) -> type 0, imm 0, tgt_o pc+4
//  6 rst_ni low while FULL -> same cycle valid_o=0, ready_o=1; after release,
//    first push appears 1 cycle later

Source files
------------

// File: rtl/decode_imm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : decode_imm_ctrl
// Purpose  : Decode-stage controller that classifies RV32I opcodes, sign-extends
//            the immediate and buffers entries in a 2-deep skid queue.
// Options  : DECODE_BR_TARGET_EN adds tgt_o (branch/jump target or pc+4).
// Revision : 1.0
// ============================================================================
module decode_imm_ctrl #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      imm_type_o
`ifdef DECODE_BR_TARGET_EN
    ,
    output logic [XLEN-1:0] tgt_o
`endif
);

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
`ifdef DECODE_BR_TARGET_EN
        logic [XLEN-1:0] tgt;
`endif
    } entry_t;

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    entry_t w_new;
    entry_t w_idle;
    logic   w_push;
    logic   w_pop;

    // Idle entry: what the outputs show whenever the queue holds nothing.
    always_comb begin
        w_idle      = '0;
        w_idle.inst = NOP_INST;
    end

    always_comb begin
        w_new      = '0;
        w_new.inst = inst_i;
        w_new.pc   = pc_i;
        case (inst_i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_new.typ = IMM_I;
                w_new.imm = {{20{inst_i[31]}}, inst_i[31:20]};
            end
            7'b0100011: begin
                w_new.typ = IMM_S;
                w_new.imm = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            end
            7'b1100011: begin
                w_new.typ = IMM_B;
                w_new.imm = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                             inst_i[30:25], inst_i[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_new.typ = IMM_U;
                w_new.imm = {inst_i[31:12], 12'b0};
            end
            7'b1101111: begin
                w_new.typ = IMM_J;
                w_new.imm = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                             inst_i[20], inst_i[30:21], 1'b0};
            end
            default: begin
                w_new.typ = IMM_NONE;
                w_new.imm = '0;
            end
        endcase
`ifdef DECODE_BR_TARGET_EN
        if (w_new.typ == IMM_B || w_new.typ == IMM_J) begin
            w_new.tgt = pc_i + w_new.imm;
        end else begin
            w_new.tgt = pc_i + XLEN'(4);
        end
`endif
    end

    assign ready_o = (state_q != FULL);
    assign valid_o = (state_q != EMPTY);
    assign w_push  = valid_i & ready_o & ~flush_i;
    assign w_pop   = valid_o & ready_i & ~flush_i;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_i) begin
            state_d = EMPTY;
            head_d  = w_idle;
            tail_d  = w_idle;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (w_push) begin
                        state_d = ONE;
                        head_d  = w_new;
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        head_d = w_new;
                    end else if (w_push) begin
                        state_d = FULL;
                        tail_d  = w_new;
                    end else if (w_pop) begin
                        state_d = EMPTY;
                        head_d  = w_idle;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        state_d = ONE;
                        head_d  = tail_q;
                        tail_d  = w_idle;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    head_d  = w_idle;
                    tail_d  = w_idle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            head_q  <= w_idle;
            tail_q  <= w_idle;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign inst_o     = head_q.inst;
    assign pc_o       = head_q.pc;
    assign imm_o      = head_q.imm;
    assign imm_type_o = head_q.typ;
`ifdef DECODE_BR_TARGET_EN
    assign tgt_o      = head_q.tgt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_imm_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_imm_ctrl
// Purpose  : Directed vector bench for decode_imm_ctrl (tgt_o checks only when
//            DECODE_BR_TARGET_EN is defined).
// Revision : 1.0
// ============================================================================
module tb_decode_imm_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] inst_i = '0;
    logic [31:0] pc_i = '0;
    logic        flush_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] imm_o;
    logic [2:0]  imm_type_o;
`ifdef DECODE_BR_TARGET_EN
    logic [31:0] tgt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    decode_imm_ctrl #(.XLEN(32), .NOP_INST(NOP)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .inst_i     (inst_i),
        .pc_i       (pc_i),
        .flush_i    (flush_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .inst_o     (inst_o),
        .pc_o       (pc_o),
        .imm_o      (imm_o),
        .imm_type_o (imm_type_o)
`ifdef DECODE_BR_TARGET_EN
        ,
        .tgt_o      (tgt_o)
`endif
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  typ;
        logic [31:0] imm;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " valid_o"}, 32'(valid_o), 32'd0);
        chk({tag, " ready_o"}, 32'(ready_o), 32'd1);
        chk({tag, " inst_o"}, inst_o, NOP);
        chk({tag, " pc_o"}, pc_o, 32'd0);
        chk({tag, " imm_o"}, imm_o, 32'd0);
        chk({tag, " imm_type_o"}, 32'(imm_type_o), 32'd0);
`ifdef DECODE_BR_TARGET_EN
        chk({tag, " tgt_o"}, tgt_o, 32'd0);
`endif
    endtask

    task automatic chk_vec(input string tag, input vec_t v);
        chk({tag, " valid_o"}, 32'(valid_o), 32'd1);
        chk({tag, " inst_o"}, inst_o, v.inst);
        chk({tag, " pc_o"}, pc_o, v.pc);
        chk({tag, " imm_type_o"}, 32'(imm_type_o), 32'(v.typ));
        chk({tag, " imm_o"}, imm_o, v.imm);
`ifdef DECODE_BR_TARGET_EN
        chk({tag, " tgt_o"}, tgt_o, v.tgt);
`endif
    endtask

    task automatic drive(input vec_t v);
        valid_i = 1'b1;
        inst_i  = v.inst;
        pc_i    = v.pc;
    endtask

    vec_t va, vb, vc, vx;

    initial begin
        //           inst           pc             type  imm            tgt
        vecs[0]  = '{32'hFE000EE3, 32'h0000_0100, 3'd3, 32'hFFFFFFFC, 32'h0000_00FC};
        vecs[1]  = '{32'h00512423, 32'h0000_0200, 3'd2, 32'h0000_0008, 32'h0000_0204};
        vecs[2]  = '{32'h123450B7, 32'h0000_0300, 3'd4, 32'h1234_5000, 32'h0000_0304};
        vecs[3]  = '{32'h0080006F, 32'h0000_0400, 3'd5, 32'h0000_0008, 32'h0000_0408};
        vecs[4]  = '{32'h00B50533, 32'h0000_0500, 3'd0, 32'h0000_0000, 32'h0000_0504};
        vecs[5]  = '{32'hFFF00093, 32'h0000_0600, 3'd1, 32'hFFFFFFFF, 32'h0000_0604};
        vecs[6]  = '{32'h00452083, 32'h0000_0700, 3'd1, 32'h0000_0004, 32'h0000_0704};
        vecs[7]  = '{32'h80008067, 32'h0000_0800, 3'd1, 32'hFFFFF800, 32'h0000_0804};
        vecs[8]  = '{32'hFFFFF017, 32'h0000_0900, 3'd4, 32'hFFFFF000, 32'h0000_0904};
        vecs[9]  = '{32'h0080006F, 32'hFFFFFFFC, 3'd5, 32'h0000_0008, 32'h0000_0004};
        vecs[10] = '{32'hFFDFF06F, 32'h0000_0200, 3'd5, 32'hFFFFFFFC, 32'h0000_01FC};
        vecs[11] = '{32'hFE512E23, 32'h0000_0A00, 3'd2, 32'hFFFFFFFC, 32'h0000_0A04};

        #12;
        chk_idle("reset");
        rst_ni = 1'b1;
        step();
        chk_idle("post-reset");

        // Single-entry vectors, execute always ready.
        ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i]);
            step();
            valid_i = 1'b0;
            chk_vec($sformatf("vec%0d", i), vecs[i]);
            step();
            chk($sformatf("vec%0d drained", i), 32'(valid_o), 32'd0);
        end
        chk("drain inst_o NOP", inst_o, NOP);

        // Full throughput: each push shows up the following cycle.
        for (int i = 0; i < 3; i++) begin
            drive(vecs[i]);
            step();
            chk_vec($sformatf("stream%0d", i), vecs[i]);
            chk($sformatf("stream%0d ready_o", i), 32'(ready_o), 32'd1);
        end
        valid_i = 1'b0;
        step();
        chk("stream drained", 32'(valid_o), 32'd0);

        // Backpressure: A,B fill the queue, C is held by fetch.
        va = vecs[1]; vb = vecs[2]; vc = vecs[3];
        ready_i = 1'b0;
        drive(va);
        step();
        chk("bp after A ready_o", 32'(ready_o), 32'd1);
        drive(vb);
        step();
        chk("bp after B ready_o", 32'(ready_o), 32'd0);
        drive(vc);
        step();
        chk("bp stall ready_o", 32'(ready_o), 32'd0);
        chk_vec("bp head held A", va);
        ready_i = 1'b1;
        step();
        chk_vec("bp out B", vb);
        chk("bp ONE ready_o", 32'(ready_o), 32'd1);
        step();
        valid_i = 1'b0;
        chk_vec("bp out C", vc);
        step();
        chk_idle("bp drained");

        // Flush while full with a simultaneous incoming entry.
        vx = vecs[5];
        ready_i = 1'b0;
        drive(va);
        step();
        drive(vb);
        step();
        chk("flush pre ready_o", 32'(ready_o), 32'd0);
        drive(vx);
        flush_i = 1'b1;
        ready_i = 1'b1;
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk_idle("flush");
        step();
        chk("flush no leak valid_o", 32'(valid_o), 32'd0);
        chk("flush no leak inst_o", inst_o, NOP);

        // Reset asserted mid-cycle while full.
        ready_i = 1'b0;
        drive(va);
        step();
        drive(vb);
        step();
        valid_i = 1'b0;
        chk("rst pre valid_o", 32'(valid_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk_idle("async reset");
        step();
        rst_ni = 1'b1;
        ready_i = 1'b1;
        step();
        chk_idle("after release");
        drive(vc);
        step();
        valid_i = 1'b0;
        chk_vec("post-reset push", vc);
        step();
        chk_idle("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
